// File: rtl/s2_kes_me_pt.sv
// s2_kes_me_pt: stage-2 Reed-Solomon key-equation solver.
// Runs the inversion-free modified Euclidean algorithm over GF(2^8) (poly 0x11D).
// It takes 2T syndromes and returns the error locator (lambda) and the error
// evaluator (omega). Both carry one common, non-normalised scale factor.

// One coefficient lane of a reduction step: z = b*x ^ a*y over GF(2^8).
module s2_kes_gf_mac (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] z
);
    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] m;
        acc = 8'h00;
        m   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    assign z = gf_mul(b, x) ^ gf_mul(a, y);
endmodule

module s2_kes_me_pt #(
    parameter  int T  = 8,
    localparam int DW = $clog2(2*T+1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                syn_vld,
    output logic                syn_rdy,
    input  logic [16*T-1:0]     syn,
    output logic                kes_vld,
    input  logic                kes_rdy,
    output logic [8*(T+1)-1:0]  lambda,
    output logic [8*T-1:0]      omega,
    output logic [DW-1:0]       lambda_deg,
    output logic                err_free,
    output logic                kes_fail
);
    localparam int NR = 2*T+1;   // coefficients of R/Q (degree up to 2T)
    localparam int NL = T+1;     // coefficients of L/U (degree up to T)

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [NR-1:0][7:0] r_q, q_q;
    logic [NL-1:0][7:0] l_q, u_q;
    logic [DW-1:0]      dr_q, dq_q, iter_q;

    logic               swap;
    logic [NR-1:0][7:0] rs, qs, qsh, r_n;
    logic [NL-1:0][7:0] ls, us, ush, l_n;
    logic [DW-1:0]      drs, dqs, sh, dr_n, dl_n, iter_n, syn_deg;
    logic [7:0]         coef_a, coef_b;
    logic               syn_zero, q_zero, term, exhaust, run_end, fail_n, accept;

    // Handshake flags decode directly from the state register.
    assign syn_rdy = (state == IDLE);
    assign kes_vld = (state == DONE);
    assign accept  = syn_vld & syn_rdy;

    // Operand selection for one step: optional swap, leading coefficients, alignment shift
    always_comb begin
        swap   = (dr_q < dq_q);
        rs     = swap ? q_q  : r_q;
        qs     = swap ? r_q  : q_q;
        ls     = swap ? u_q  : l_q;
        us     = swap ? l_q  : u_q;
        drs    = swap ? dq_q : dr_q;
        dqs    = swap ? dr_q : dq_q;
        sh     = drs - dqs;
        coef_a = rs[drs];
        coef_b = qs[dqs];
        qsh    = qs << {sh, 3'b000};
        ush    = us << {sh, 3'b000};
    end

    // Cross-multiply lanes: the leading term of R cancels each step.
    for (genvar i = 0; i < NR; i++) begin : g_rmac
        s2_kes_gf_mac u_mac (.a(coef_a), .b(coef_b), .x(rs[i]), .y(qsh[i]), .z(r_n[i]));
    end
    for (genvar i = 0; i < NL; i++) begin : g_lmac
        s2_kes_gf_mac u_mac (.a(coef_a), .b(coef_b), .x(ls[i]), .y(ush[i]), .z(l_n[i]));
    end

    // Degree searches, termination and failure detection on the post-step values
    always_comb begin
        dr_n    = '0;
        dl_n    = '0;
        syn_deg = '0;
        for (int i = 0; i < NR; i++)  if (r_n[i] != 8'h00)          dr_n    = DW'(i);
        for (int i = 0; i < NL; i++)  if (l_n[i] != 8'h00)          dl_n    = DW'(i);
        for (int i = 0; i < 2*T; i++) if (syn[8*i +: 8] != 8'h00)   syn_deg = DW'(i);
        syn_zero = (syn == '0);
        q_zero   = (qs == '0);
        iter_n   = iter_q + 1'b1;
        term     = (dr_n < DW'(T));
        exhaust  = (iter_n == DW'(2*T));
        run_end  = q_zero | term | exhaust;
        // A non-terminating exit (Q zero or iterations used up) is always a failure.
        fail_n   = q_zero | ~term | (l_n[0] == 8'h00) | (dl_n > DW'(T)) | (dr_n >= dl_n);
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (syn_vld) state_n = syn_zero ? DONE : RUN;
            RUN:     if (run_end) state_n = DONE;
            DONE:    if (kes_rdy) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Working polynomials and result registers; results only change on entry to DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q        <= '0;
            q_q        <= '0;
            l_q        <= '0;
            u_q        <= '0;
            dr_q       <= '0;
            dq_q       <= '0;
            iter_q     <= '0;
            lambda     <= '0;
            omega      <= '0;
            lambda_deg <= '0;
            err_free   <= 1'b0;
            kes_fail   <= 1'b0;
        end else if (accept) begin
            r_q    <= {8'h01, {(16*T){1'b0}}};
            q_q    <= {8'h00, syn};
            l_q    <= '0;
            u_q    <= {{(8*T){1'b0}}, 8'h01};
            dr_q   <= DW'(2*T);
            dq_q   <= syn_deg;
            iter_q <= '0;
            if (syn_zero) begin
                lambda     <= {{(8*T){1'b0}}, 8'h01};
                omega      <= '0;
                lambda_deg <= '0;
                err_free   <= 1'b1;
                kes_fail   <= 1'b0;
            end
        end else if (state == RUN) begin
            r_q    <= r_n;
            q_q    <= qs;
            l_q    <= l_n;
            u_q    <= us;
            dr_q   <= dr_n;
            dq_q   <= dqs;
            iter_q <= iter_n;
            if (run_end) begin
                lambda     <= l_n;
                omega      <= r_n[T-1:0];
                lambda_deg <= dl_n;
                err_free   <= 1'b0;
                kes_fail   <= fail_n;
            end
        end
    end
endmodule
